// File: rtl/knight_uart_pkg.sv
// Shared types and constants for the RemoteComm UART command endpoint.
package knight_uart_pkg;

    localparam int unsigned BAUD_CYCLES_DEFAULT    = 434;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 2000000;

    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_ACK  = 8'h5A;

    typedef enum logic {WAIT_HIGH, WAIT_LOW} asm_state_t;
    typedef enum logic {IDLE, SEND} tx_state_t;
    typedef enum logic {RX_IDLE, RX_BUSY} rx_state_t;

    // Counter width able to hold the values 0 .. n-1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser: start bit, 8 data bits LSB-first, stop bit; tx_done level when finished.
module uart_byte_tx
    import knight_uart_pkg::*;
#(
    parameter int unsigned BAUD_CYCLES = BAUD_CYCLES_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_trmt,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic       o_tx_done
);

    localparam int unsigned      BW        = cnt_width(BAUD_CYCLES);
    localparam logic [BW-1:0]    BAUD_LAST = BW'(BAUD_CYCLES - 1);

    tx_state_t      r_state;
    logic [8:0]     r_shift;
    logic [BW-1:0]  r_baud;
    logic [3:0]     r_bit;
    logic           r_tx;
    logic           r_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_shift <= '1;
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_trmt) begin
                        // Start bit goes out immediately; shifter holds data plus stop.
                        r_shift <= {1'b1, i_data};
                        r_tx    <= 1'b0;
                        r_done  <= 1'b0;
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud <= '0;
                        if (r_bit == 4'd9) begin
                            r_tx    <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_tx    <= r_shift[0];
                            r_shift <= {1'b1, r_shift[8:1]};
                            r_bit   <= r_bit + 4'd1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_tx      = r_tx;
    assign o_tx_done = r_done;

endmodule

// File: rtl/uart_cmd_wrapper.sv
// RemoteComm UART endpoint: assembles two received bytes into a 16-bit cmd, sends response bytes.
// Optional WAIT_LOW timeout is enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_wrapper
    import knight_uart_pkg::*;
#(
    parameter int unsigned BAUD_CYCLES = BAUD_CYCLES_DEFAULT
`ifdef UART_CMD_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic        tx_done
);

    localparam int unsigned   BW        = cnt_width(BAUD_CYCLES);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_CYCLES - 1);
    localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_CYCLES / 2);

    logic           r_rx_meta;
    logic           r_rx_sync;
    logic           r_rx_prev;
    rx_state_t      r_rx_state;
    logic [BW-1:0]  r_rx_baud;
    logic [3:0]     r_rx_bit;
    logic [7:0]     r_rx_shift;
    logic           r_rx_rdy;
    logic           r_frame_err;
    logic           w_rx_fall;

    asm_state_t     r_asm_state;
    logic [15:0]    r_cmd;
    logic           r_cmd_rdy;

    assign w_rx_fall = r_rx_prev & ~r_rx_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta   <= 1'b1;
            r_rx_sync   <= 1'b1;
            r_rx_prev   <= 1'b1;
            r_rx_state  <= RX_IDLE;
            r_rx_baud   <= '0;
            r_rx_bit    <= '0;
            r_rx_shift  <= '0;
            r_rx_rdy    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_meta   <= RX;
            r_rx_sync   <= r_rx_meta;
            r_rx_prev   <= r_rx_sync;
            r_rx_rdy    <= 1'b0;
            r_frame_err <= 1'b0;
            unique case (r_rx_state)
                RX_IDLE: begin
                    if (w_rx_fall) begin
                        r_rx_baud  <= BAUD_HALF;
                        r_rx_bit   <= '0;
                        r_rx_state <= RX_BUSY;
                    end
                end
                RX_BUSY: begin
                    if (r_rx_baud != '0) begin
                        r_rx_baud <= r_rx_baud - 1'b1;
                    end else begin
                        r_rx_baud <= BAUD_LAST;
                        r_rx_bit  <= r_rx_bit + 4'd1;
                        if (r_rx_bit == 4'd0) begin
                            if (r_rx_sync) r_rx_state <= RX_IDLE;
                        end else if (r_rx_bit == 4'd9) begin
                            r_rx_state <= RX_IDLE;
                            if (r_rx_sync) r_rx_rdy    <= 1'b1;
                            else           r_frame_err <= 1'b1;
                        end else begin
                            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                        end
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

`ifdef UART_CMD_TIMEOUT_EN
    localparam int unsigned   TW      = cnt_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0]            r_to_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (r_rx_rdy || (r_asm_state != WAIT_LOW) || (r_to_cnt == TO_LAST)) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_asm_state <= WAIT_HIGH;
            r_cmd       <= '0;
            r_cmd_rdy   <= 1'b0;
        end else begin
            // Clear first so a same-cycle low-byte completion below wins.
            if (clr_cmd_rdy) r_cmd_rdy <= 1'b0;
            if (r_frame_err) begin
                r_asm_state <= WAIT_HIGH;
            end else if (r_rx_rdy) begin
                unique case (r_asm_state)
                    WAIT_HIGH: begin
                        r_cmd[15:8] <= r_rx_shift;
                        r_cmd_rdy   <= 1'b0;
                        r_asm_state <= WAIT_LOW;
                    end
                    WAIT_LOW: begin
                        r_cmd[7:0]  <= r_rx_shift;
                        r_cmd_rdy   <= 1'b1;
                        r_asm_state <= WAIT_HIGH;
                    end
                    default: r_asm_state <= WAIT_HIGH;
                endcase
`ifdef UART_CMD_TIMEOUT_EN
            end else if ((r_asm_state == WAIT_LOW) && (r_to_cnt == TO_LAST)) begin
                r_asm_state <= WAIT_HIGH;
`endif
            end
        end
    end

    uart_byte_tx #(
        .BAUD_CYCLES(BAUD_CYCLES)
    ) u_tx (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_trmt   (trmt),
        .i_data   (resp),
        .o_tx     (TX),
        .o_tx_done(tx_done)
    );

    assign cmd     = r_cmd;
    assign cmd_rdy = r_cmd_rdy;

endmodule
